// File: rtl/sc_vehicle_lane_register_if.sv
// Load/shift bus between the level state machine (master) and one lane
// register (slave). Define SC_VEHICLE_LANE_COLLISION_EN to add the frog
// position input and the collision flag.
interface sc_vehicle_lane_register_if #(
    parameter int DATAWIDTH_BUS = 8
);

    logic                     SC_VEHICLE_LANE_LOAD_IN;
    logic                     SC_VEHICLE_LANE_SHIFT_IN;
    logic [DATAWIDTH_BUS-1:0] SC_VEHICLE_LANE_DATA_IN;
    logic [1:0]               SC_VEHICLE_LANE_CLOCK_SELECT;
    logic                     SC_VEHICLE_LANE_HAB_CLOCK0_IN;
    logic                     SC_VEHICLE_LANE_HAB_CLOCK1_IN;
    logic                     SC_VEHICLE_LANE_HAB_CLOCK2_IN;
    logic [DATAWIDTH_BUS-1:0] SC_VEHICLE_LANE_DATA_OUT;
    logic                     SC_VEHICLE_LANE_LOADED_OUT;
    logic                     SC_VEHICLE_LANE_TICK_OUT;
`ifdef SC_VEHICLE_LANE_COLLISION_EN
    logic [DATAWIDTH_BUS-1:0] SC_VEHICLE_LANE_FROG_IN;
    logic                     SC_VEHICLE_LANE_HIT_OUT;

    modport master (
        output SC_VEHICLE_LANE_LOAD_IN, SC_VEHICLE_LANE_SHIFT_IN,
               SC_VEHICLE_LANE_DATA_IN, SC_VEHICLE_LANE_CLOCK_SELECT,
               SC_VEHICLE_LANE_HAB_CLOCK0_IN, SC_VEHICLE_LANE_HAB_CLOCK1_IN,
               SC_VEHICLE_LANE_HAB_CLOCK2_IN, SC_VEHICLE_LANE_FROG_IN,
        input  SC_VEHICLE_LANE_DATA_OUT, SC_VEHICLE_LANE_LOADED_OUT,
               SC_VEHICLE_LANE_TICK_OUT, SC_VEHICLE_LANE_HIT_OUT
    );

    modport slave (
        input  SC_VEHICLE_LANE_LOAD_IN, SC_VEHICLE_LANE_SHIFT_IN,
               SC_VEHICLE_LANE_DATA_IN, SC_VEHICLE_LANE_CLOCK_SELECT,
               SC_VEHICLE_LANE_HAB_CLOCK0_IN, SC_VEHICLE_LANE_HAB_CLOCK1_IN,
               SC_VEHICLE_LANE_HAB_CLOCK2_IN, SC_VEHICLE_LANE_FROG_IN,
        output SC_VEHICLE_LANE_DATA_OUT, SC_VEHICLE_LANE_LOADED_OUT,
               SC_VEHICLE_LANE_TICK_OUT, SC_VEHICLE_LANE_HIT_OUT
    );
`else
    modport master (
        output SC_VEHICLE_LANE_LOAD_IN, SC_VEHICLE_LANE_SHIFT_IN,
               SC_VEHICLE_LANE_DATA_IN, SC_VEHICLE_LANE_CLOCK_SELECT,
               SC_VEHICLE_LANE_HAB_CLOCK0_IN, SC_VEHICLE_LANE_HAB_CLOCK1_IN,
               SC_VEHICLE_LANE_HAB_CLOCK2_IN,
        input  SC_VEHICLE_LANE_DATA_OUT, SC_VEHICLE_LANE_LOADED_OUT,
               SC_VEHICLE_LANE_TICK_OUT
    );

    modport slave (
        input  SC_VEHICLE_LANE_LOAD_IN, SC_VEHICLE_LANE_SHIFT_IN,
               SC_VEHICLE_LANE_DATA_IN, SC_VEHICLE_LANE_CLOCK_SELECT,
               SC_VEHICLE_LANE_HAB_CLOCK0_IN, SC_VEHICLE_LANE_HAB_CLOCK1_IN,
               SC_VEHICLE_LANE_HAB_CLOCK2_IN,
        output SC_VEHICLE_LANE_DATA_OUT, SC_VEHICLE_LANE_LOADED_OUT,
               SC_VEHICLE_LANE_TICK_OUT
    );
`endif

endinterface

// File: rtl/sc_vehicle_lane_register.sv
// Vehicle lane register: captures the level pattern through a LOAD/LOADED
// handshake, then rotates it one bit per prescaler period while the level
// FSM requests SHIFT. Optional collision detection is built when
// SC_VEHICLE_LANE_COLLISION_EN is defined.
module sc_vehicle_lane_register #(
    parameter int DATAWIDTH_BUS   = 8,
    parameter int PRESCALER_WIDTH = 26,
    parameter int DIV_SLOW        = 25000000,
    parameter int DIV_MED         = 12500000,
    parameter int DIV_FAST        = 6250000,
    parameter bit SHIFT_LEFT      = 1'b1
) (
    input  logic                      SC_VEHICLE_LANE_CLOCK_50,
    input  logic                      SC_VEHICLE_LANE_RESET,
    sc_vehicle_lane_register_if.slave lane_bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_ACK,
        ST_RUN
    } lane_state_t;

    typedef logic [PRESCALER_WIDTH-1:0] presc_t;
    typedef logic [DATAWIDTH_BUS-1:0]   lane_t;

    // Terminal prescaler count; a divisor of 0 or 1 ticks every valid cycle.
    function automatic presc_t div_last(input int div);
        if (div <= 1) return '0;
        return presc_t'(div - 1);
    endfunction

    localparam presc_t SLOW_LAST = div_last(DIV_SLOW);
    localparam presc_t MED_LAST  = div_last(DIV_MED);
    localparam presc_t FAST_LAST = div_last(DIV_FAST);

    lane_state_t state_r, state_nxt;
    lane_t       data_r, data_nxt;
    logic        loaded_r, loaded_nxt;
    logic        tick_r, tick_nxt;
    presc_t      presc_r, presc_nxt;
    logic [1:0]  sel_prev_r;

    logic        load;
    logic        shift;
    lane_t       din;
    logic [1:0]  sel;
    logic        speed_valid;
    presc_t      presc_last;
    lane_t       data_rot;

    assign load  = lane_bus.SC_VEHICLE_LANE_LOAD_IN;
    assign shift = lane_bus.SC_VEHICLE_LANE_SHIFT_IN;
    assign din   = lane_bus.SC_VEHICLE_LANE_DATA_IN;
    assign sel   = lane_bus.SC_VEHICLE_LANE_CLOCK_SELECT;

    // Speed enable pairing and divisor for the selected lane speed.
    always_comb begin
        speed_valid = 1'b0;
        presc_last  = SLOW_LAST;
        case (sel)
            2'b01: begin
                speed_valid = lane_bus.SC_VEHICLE_LANE_HAB_CLOCK2_IN;
                presc_last  = SLOW_LAST;
            end
            2'b10: begin
                speed_valid = lane_bus.SC_VEHICLE_LANE_HAB_CLOCK1_IN;
                presc_last  = MED_LAST;
            end
            2'b11: begin
                speed_valid = lane_bus.SC_VEHICLE_LANE_HAB_CLOCK0_IN;
                presc_last  = FAST_LAST;
            end
            default: begin
                speed_valid = 1'b0;
                presc_last  = SLOW_LAST;
            end
        endcase
    end

    // One-bit rotation of the current row; bits wrap around, none are lost.
    always_comb begin
        if (SHIFT_LEFT)
            data_rot = (data_r << 1) | (data_r >> (DATAWIDTH_BUS - 1));
        else
            data_rot = (data_r >> 1) | (data_r << (DATAWIDTH_BUS - 1));
    end

    // Next-state and next-output logic; LOAD takes priority in every state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nxt  = state_r;
        data_nxt   = data_r;
        loaded_nxt = 1'b0;
        tick_nxt   = 1'b0;
        presc_nxt  = presc_r;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    if (din != '0) begin
                        state_nxt = ST_CAPTURE;
                        data_nxt  = din;
                    end else begin
                        data_nxt = '0;
                    end
                end
            end
            ST_CAPTURE: begin
                if (load) begin
                    if (din == data_r) state_nxt = ST_ACK;
                    else               data_nxt  = din;
                end else begin
                    state_nxt = ST_IDLE;
                    data_nxt  = '0;
                end
            end
            ST_ACK: begin
                if (shift && !load) begin
                    state_nxt = ST_RUN;
                    presc_nxt = '0;
                end else begin
                    loaded_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (load) begin
                    state_nxt = ST_IDLE;
                    data_nxt  = '0;
                    presc_nxt = '0;
                end else if (sel != sel_prev_r) begin
                    presc_nxt = '0;
                end else if (shift && speed_valid) begin
                    if (presc_r >= presc_last) begin
                        presc_nxt = '0;
                        tick_nxt  = 1'b1;
                        data_nxt  = data_rot;
                    end else begin
                        presc_nxt = presc_r + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                data_nxt  = '0;
                presc_nxt = '0;
            end
        endcase
    end

`ifdef SC_VEHICLE_LANE_COLLISION_EN
    logic hit_r, hit_nxt;

    // Sticky collision flag, cleared by a new load request.
    always_comb begin
        hit_nxt = hit_r;
        if (load)
            hit_nxt = 1'b0;
        else if (state_r == ST_RUN && |(data_r & lane_bus.SC_VEHICLE_LANE_FROG_IN))
            hit_nxt = 1'b1;
    end

    // Collision flag register.
    always_ff @(posedge SC_VEHICLE_LANE_CLOCK_50) begin
        if (SC_VEHICLE_LANE_RESET) hit_r <= 1'b0;
        else                       hit_r <= hit_nxt;
    end

    assign lane_bus.SC_VEHICLE_LANE_HIT_OUT = hit_r;
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge SC_VEHICLE_LANE_CLOCK_50) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (SC_VEHICLE_LANE_RESET) begin
            state_r    <= ST_IDLE;
            data_r     <= '0;
            loaded_r   <= 1'b0;
            tick_r     <= 1'b0;
            presc_r    <= '0;
            sel_prev_r <= 2'b00;
        end else begin
            state_r    <= state_nxt;
            data_r     <= data_nxt;
            loaded_r   <= loaded_nxt;
            tick_r     <= tick_nxt;
            presc_r    <= presc_nxt;
            sel_prev_r <= sel;
        end
    end

    assign lane_bus.SC_VEHICLE_LANE_DATA_OUT   = data_r;
    assign lane_bus.SC_VEHICLE_LANE_LOADED_OUT = loaded_r;
    assign lane_bus.SC_VEHICLE_LANE_TICK_OUT   = tick_r;

endmodule
